id_ex_pipeline_reg: RTL and testbench

- ID/EX pipeline register of the 5-stage MIPS datapath; sits directly downstream of the opcode decoder (control unit) and the register file / sign extender.
- Captures decoded control bits plus ID-stage operands each cycle and presents them to EX.
- Supports hold (stall), NOP-bubble insertion (load-use hazard) and full flush (branch taken).
- Keeps a saturating count of inserted bubbles/flushes for performance measurement.

---
 rtl/id_ex_pipeline_reg.sv | 127 ++++++++++++
 tb/tb_id_ex_pipeline_reg.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: one-cycle registered copy of decoded control and operands.
// Flush clears everything; bubble zeroes control only; stall holds all contents.
module id_ex_pipeline_reg #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      Stall,
   input  logic                      Bubble,
   input  logic                      Flush,
   input  logic                      Valid_in,
   input  logic                      RegDst_in,
   input  logic                      Branch_in,
   input  logic                      MemRead_in,
   input  logic                      MemtoReg_in,
   input  logic                      MemWrite_in,
   input  logic                      ALUSrc_in,
   input  logic                      RegWrite_in,
   input  logic [2:0]                ALUOp_in,
   input  logic [DATA_WIDTH-1:0]     PCPlus4_in,
   input  logic [DATA_WIDTH-1:0]     ReadData1_in,
   input  logic [DATA_WIDTH-1:0]     ReadData2_in,
   input  logic [DATA_WIDTH-1:0]     SignExt_in,
   input  logic [REG_ADDR_WIDTH-1:0] Rs_in,
   input  logic [REG_ADDR_WIDTH-1:0] Rt_in,
   input  logic [REG_ADDR_WIDTH-1:0] Rd_in,
   input  logic [REG_ADDR_WIDTH-1:0] Shamt_in,
   input  logic [5:0]                Funct_in,
   output logic                      Valid_out,
   output logic                      RegDst_out,
   output logic                      Branch_out,
   output logic                      MemRead_out,
   output logic                      MemtoReg_out,
   output logic                      MemWrite_out,
   output logic                      ALUSrc_out,
   output logic                      RegWrite_out,
   output logic [2:0]                ALUOp_out,
   output logic [DATA_WIDTH-1:0]     PCPlus4_out,
   output logic [DATA_WIDTH-1:0]     ReadData1_out,
   output logic [DATA_WIDTH-1:0]     ReadData2_out,
   output logic [DATA_WIDTH-1:0]     SignExt_out,
   output logic [REG_ADDR_WIDTH-1:0] Rs_out,
   output logic [REG_ADDR_WIDTH-1:0] Rt_out,
   output logic [REG_ADDR_WIDTH-1:0] Rd_out,
   output logic [REG_ADDR_WIDTH-1:0] Shamt_out,
   output logic [5:0]                Funct_out,
   output logic [CNT_WIDTH-1:0]      BubbleCount
);

   localparam int CTRL_W = 10;

   logic [CTRL_W-1:0] ctrl_d;
   logic [CTRL_W-1:0] ctrl_q;
   logic              kill_ctrl;
   logic              load_data;
   logic              cnt_sat;

   assign ctrl_d = {RegDst_in, Branch_in, MemRead_in, MemtoReg_in,
                    MemWrite_in, ALUSrc_in, RegWrite_in, ALUOp_in};

   assign {RegDst_out, Branch_out, MemRead_out, MemtoReg_out,
           MemWrite_out, ALUSrc_out, RegWrite_out, ALUOp_out} = ctrl_q;

   // A bubble or flush overrides a simultaneous stall.
   assign kill_ctrl = Flush | Bubble;
   assign load_data = Bubble | ~Stall;
   assign cnt_sat   = (BubbleCount == {CNT_WIDTH{1'b1}});

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         ctrl_q    <= '0;
         Valid_out <= 1'b0;
      end else if (kill_ctrl) begin
         ctrl_q    <= '0;
         Valid_out <= 1'b0;
      end else if (!Stall) begin
         ctrl_q    <= ctrl_d;
         Valid_out <= Valid_in;
      end
   end

   // Operands still pass through on a bubble so forwarding/debug can see them.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         PCPlus4_out   <= '0;
         ReadData1_out <= '0;
         ReadData2_out <= '0;
         SignExt_out   <= '0;
         Rs_out        <= '0;
         Rt_out        <= '0;
         Rd_out        <= '0;
         Shamt_out     <= '0;
         Funct_out     <= '0;
      end else if (Flush) begin
         PCPlus4_out   <= '0;
         ReadData1_out <= '0;
         ReadData2_out <= '0;
         SignExt_out   <= '0;
         Rs_out        <= '0;
         Rt_out        <= '0;
         Rd_out        <= '0;
         Shamt_out     <= '0;
         Funct_out     <= '0;
      end else if (load_data) begin
         PCPlus4_out   <= PCPlus4_in;
         ReadData1_out <= ReadData1_in;
         ReadData2_out <= ReadData2_in;
         SignExt_out   <= SignExt_in;
         Rs_out        <= Rs_in;
         Rt_out        <= Rt_in;
         Rd_out        <= Rd_in;
         Shamt_out     <= Shamt_in;
         Funct_out     <= Funct_in;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         BubbleCount <= '0;
      end else if (kill_ctrl && !cnt_sat) begin
         BubbleCount <= BubbleCount + 1'b1;
      end
   end

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Directed bench for id_ex_pipeline_reg with a 4-bit bubble counter so saturation is reachable.
module tb_id_ex_pipeline_reg;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 4;

   logic          Clk, Reset, Stall, Bubble, Flush, Valid_in;
   logic          RegDst_in, Branch_in, MemRead_in, MemtoReg_in, MemWrite_in, ALUSrc_in, RegWrite_in;
   logic [2:0]    ALUOp_in;
   logic [DW-1:0] PCPlus4_in, ReadData1_in, ReadData2_in, SignExt_in;
   logic [AW-1:0] Rs_in, Rt_in, Rd_in, Shamt_in;
   logic [5:0]    Funct_in;
   logic          Valid_out;
   logic          RegDst_out, Branch_out, MemRead_out, MemtoReg_out, MemWrite_out, ALUSrc_out, RegWrite_out;
   logic [2:0]    ALUOp_out;
   logic [DW-1:0] PCPlus4_out, ReadData1_out, ReadData2_out, SignExt_out;
   logic [AW-1:0] Rs_out, Rt_out, Rd_out, Shamt_out;
   logic [5:0]    Funct_out;
   logic [CW-1:0] BubbleCount;

   logic [164:0] all_out;
   assign all_out = {RegDst_out, Branch_out, MemRead_out, MemtoReg_out, MemWrite_out, ALUSrc_out,
                     RegWrite_out, ALUOp_out, PCPlus4_out, ReadData1_out, ReadData2_out, SignExt_out,
                     Rs_out, Rt_out, Rd_out, Shamt_out, Funct_out, Valid_out};

   int n_assert = 0;
   int n_fail   = 0;

   id_ex_pipeline_reg #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .Clk(Clk), .Reset(Reset), .Stall(Stall), .Bubble(Bubble), .Flush(Flush), .Valid_in(Valid_in),
      .RegDst_in(RegDst_in), .Branch_in(Branch_in), .MemRead_in(MemRead_in), .MemtoReg_in(MemtoReg_in),
      .MemWrite_in(MemWrite_in), .ALUSrc_in(ALUSrc_in), .RegWrite_in(RegWrite_in), .ALUOp_in(ALUOp_in),
      .PCPlus4_in(PCPlus4_in), .ReadData1_in(ReadData1_in), .ReadData2_in(ReadData2_in),
      .SignExt_in(SignExt_in), .Rs_in(Rs_in), .Rt_in(Rt_in), .Rd_in(Rd_in), .Shamt_in(Shamt_in),
      .Funct_in(Funct_in), .Valid_out(Valid_out),
      .RegDst_out(RegDst_out), .Branch_out(Branch_out), .MemRead_out(MemRead_out),
      .MemtoReg_out(MemtoReg_out), .MemWrite_out(MemWrite_out), .ALUSrc_out(ALUSrc_out),
      .RegWrite_out(RegWrite_out), .ALUOp_out(ALUOp_out), .PCPlus4_out(PCPlus4_out),
      .ReadData1_out(ReadData1_out), .ReadData2_out(ReadData2_out), .SignExt_out(SignExt_out),
      .Rs_out(Rs_out), .Rt_out(Rt_out), .Rd_out(Rd_out), .Shamt_out(Shamt_out),
      .Funct_out(Funct_out), .BubbleCount(BubbleCount)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic set_all(input logic v);
      Valid_in    = v;
      RegDst_in   = v;
      Branch_in   = v;
      MemRead_in  = v;
      MemtoReg_in = v;
      MemWrite_in = v;
      ALUSrc_in   = v;
      RegWrite_in = v;
      ALUOp_in    = {3{v}};
      PCPlus4_in  = {DW{v}};
      ReadData1_in = {DW{v}};
      ReadData2_in = {DW{v}};
      SignExt_in  = {DW{v}};
      Rs_in       = {AW{v}};
      Rt_in       = {AW{v}};
      Rd_in       = {AW{v}};
      Shamt_in    = {AW{v}};
      Funct_in    = {6{v}};
   endtask

   initial begin
      // Reset held with every input at ones
      Reset  = 1'b1;
      Stall  = 1'b1;
      Bubble = 1'b1;
      Flush  = 1'b1;
      set_all(1'b1);
      repeat (3) tick();
      chk("reset_outputs", all_out, '0);
      chk("reset_count", BubbleCount, 0);

      // First edge after release follows normal rules
      Reset = 1'b0;
      Stall = 1'b0;
      Bubble = 1'b0;
      Flush = 1'b0;
      set_all(1'b0);
      RegWrite_in  = 1'b1;
      ALUOp_in     = 3'b010;
      ReadData1_in = 32'h0000_0005;
      Valid_in     = 1'b1;
      tick();
      chk("norm_regwrite", RegWrite_out, 1);
      chk("norm_aluop", ALUOp_out, 3'b010);
      chk("norm_rd1", ReadData1_out, 32'h0000_0005);
      chk("norm_valid", Valid_out, 1);
      chk("norm_count", BubbleCount, 0);

      // Stall holds data and control
      PCPlus4_in = 32'h0000_0010;
      MemRead_in = 1'b1;
      tick();
      chk("load_pc", PCPlus4_out, 32'h0000_0010);
      Stall       = 1'b1;
      PCPlus4_in  = 32'h0000_0020;
      RegWrite_in = 1'b0;
      tick();
      tick();
      chk("stall_pc", PCPlus4_out, 32'h0000_0010);
      chk("stall_memread", MemRead_out, 1);
      chk("stall_regwrite", RegWrite_out, 1);
      chk("stall_valid", Valid_out, 1);
      chk("stall_count", BubbleCount, 0);
      Stall = 1'b0;
      tick();
      chk("unstall_pc", PCPlus4_out, 32'h0000_0020);
      chk("unstall_regwrite", RegWrite_out, 0);

      // Bubble: control cleared, operands captured
      ReadData2_in = 32'hDEAD_BEEF;
      MemWrite_in  = 1'b1;
      Rt_in        = 5'd9;
      Bubble       = 1'b1;
      tick();
      chk("bub_memwrite", MemWrite_out, 0);
      chk("bub_memread", MemRead_out, 0);
      chk("bub_aluop", ALUOp_out, 0);
      chk("bub_valid", Valid_out, 0);
      chk("bub_rd2", ReadData2_out, 32'hDEAD_BEEF);
      chk("bub_rt", Rt_out, 5'd9);
      chk("bub_count", BubbleCount, 1);
      Bubble = 1'b0;
      tick();
      chk("post_bub_memwrite", MemWrite_out, 1);
      chk("post_bub_valid", Valid_out, 1);
      chk("post_bub_count", BubbleCount, 1);

      // Flush beats bubble and stall
      Flush       = 1'b1;
      Bubble      = 1'b1;
      Stall       = 1'b1;
      RegWrite_in = 1'b1;
      SignExt_in  = 32'hFFFF_FFFC;
      tick();
      chk("flush_regwrite", RegWrite_out, 0);
      chk("flush_signext", SignExt_out, 0);
      chk("flush_valid", Valid_out, 0);
      chk("flush_all", all_out, '0);
      chk("flush_count", BubbleCount, 2);

      // Bubble beats stall: data still loads
      Flush = 1'b0;
      tick();
      chk("bubstall_signext", SignExt_out, 32'hFFFF_FFFC);
      chk("bubstall_regwrite", RegWrite_out, 0);
      chk("bubstall_count", BubbleCount, 3);

      // Saturation: 3 + 12 = 15, then stays there
      Stall = 1'b0;
      repeat (12) tick();
      chk("sat_reach", BubbleCount, 4'hF);
      repeat (8) tick();
      chk("sat_hold_bubble", BubbleCount, 4'hF);
      Flush = 1'b1;
      tick();
      chk("sat_hold_flush", BubbleCount, 4'hF);

      // Async reset between edges while stalled
      Flush    = 1'b0;
      Bubble   = 1'b0;
      Rd_in    = 5'd31;
      Valid_in = 1'b1;
      tick();
      chk("pre_rst_rd", Rd_out, 5'd31);
      Stall = 1'b1;
      Rd_in = 5'd0;
      tick();
      chk("stall_rd", Rd_out, 5'd31);
      #2;
      Reset = 1'b1;
      #1;
      chk("async_rst_all", all_out, '0);
      chk("async_rst_count", BubbleCount, 0);
      #2;
      Reset = 1'b0;
      #1;
      chk("async_rst_after", all_out, '0);
      Stall = 1'b0;
      Rd_in = 5'd7;
      tick();
      chk("rel_rd", Rd_out, 5'd7);
      chk("rel_valid", Valid_out, 1);
      chk("rel_count", BubbleCount, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
